// File: rtl/bus_pkg.sv
// Shared definitions for the 8-bit crypto bus: header layout, controller ID,
// sequencer state encoding and completion status codes.
package bus_pkg;

  localparam logic [1:0] CTRL_ID = 2'b11;

  localparam int unsigned HDR_ID_LSB   = 0;
  localparam int unsigned HDR_SRC_LSB  = 2;
  localparam int unsigned HDR_DEST_LSB = 4;

  localparam logic ST_OK  = 1'b0;
  localparam logic ST_ERR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_HDR,
    S_GAP,
    S_DATA,
    S_ACK
  } seq_state_e;

  function automatic logic [7:0] make_header(input logic [1:0] dest,
                                             input logic [1:0] src,
                                             input logic [1:0] id);
    logic [7:0] h;
    h = '0;
    h[HDR_DEST_LSB +: 2] = dest;
    h[HDR_SRC_LSB +: 2]  = src;
    h[HDR_ID_LSB +: 2]   = id;
    return h;
  endfunction

endpackage

// File: rtl/bus_beat_counter.sv
// Payload beat counter with terminal compare; with BUS_TIMEOUT_EN defined it
// also carries a watchdog counting consecutive beat-less cycles.
module bus_beat_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear_i,
  input  logic       enable_i,
  input  logic       beat_i,
  input  logic [7:0] len_i,
  output logic [8:0] count_o,
  output logic       terminal_o,
  output logic       timeout_o
);

  logic [8:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (enable_i && beat_i) begin
      count_d = count_q + 9'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;
  // The beat arriving now is the last one when the count so far equals len.
  assign terminal_o = enable_i && beat_i && (count_q == {1'b0, len_i});

`ifdef BUS_TIMEOUT_EN
  localparam int unsigned WD_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = '0;
    if (enable_i && !beat_i) begin
      wd_d = wd_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end

  assign timeout_o = enable_i && !beat_i && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));
`else
  // No watchdog in this build; the parameter stays so both builds share one interface.
  localparam bit WD_PRESENT = 1'b0 && (TIMEOUT_CYCLES != 0);

  assign timeout_o = WD_PRESENT;
`endif

endmodule

// File: rtl/bus_txn_sequencer.sv
// Bus transaction initiator: drives the header as the controller node, counts
// payload beats from the source node and closes with a one-cycle ack.
// Optional watchdog abort is enabled by defining BUS_TIMEOUT_EN.
module bus_txn_sequencer
  import bus_pkg::*;
#(
  parameter int unsigned GAP_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 64,
  parameter logic [1:0]  CTRL_ID        = bus_pkg::CTRL_ID
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic [1:0] req_src,
  input  logic [1:0] req_dest,
  input  logic [7:0] req_len,
  inout  wire  [7:0] bus_data,
  inout  wire        bus_valid,
  output logic       ack,
  output logic       busy,
  output logic       done_valid,
  output logic       done_status,
  output logic [8:0] beat_count
);

  localparam int unsigned GAP_W = $clog2(GAP_CYCLES + 1);

  seq_state_e       state_q, state_d;
  logic [1:0]       src_q, src_d, dest_q, dest_d;
  logic [7:0]       len_q, len_d;
  logic [GAP_W-1:0] gap_q, gap_d;
  logic             done_valid_q, done_valid_d;
  logic             done_status_q, done_status_d;
  logic             cnt_clear, cnt_en, beat, terminal, timeout, req_bad;

  // Undriven (Z) or unknown bus_valid must never count as a beat.
  assign beat    = (bus_valid === 1'b1);
  assign req_bad = (req_src == req_dest) || (req_src == CTRL_ID) || (req_dest == CTRL_ID);

  always_comb begin
    state_d       = state_q;
    src_d         = src_q;
    dest_d        = dest_q;
    len_d         = len_q;
    gap_d         = gap_q;
    done_valid_d  = 1'b0;
    done_status_d = done_status_q;
    cnt_clear     = 1'b0;
    cnt_en        = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (req_bad) begin
            done_valid_d  = 1'b1;
            done_status_d = ST_ERR;
          end else begin
            src_d     = req_src;
            dest_d    = req_dest;
            len_d     = req_len;
            cnt_clear = 1'b1;
            state_d   = S_HDR;
          end
        end
      end
      S_HDR: begin
        gap_d   = '0;
        state_d = S_GAP;
      end
      S_GAP: begin
        cnt_en = 1'b1;
        gap_d  = gap_q + 1'b1;
        // An early source may finish a short payload before the gap expires.
        if (terminal || timeout) begin
          state_d       = S_ACK;
          done_valid_d  = 1'b1;
          done_status_d = terminal ? ST_OK : ST_ERR;
        end else if (gap_q == GAP_W'(GAP_CYCLES - 1)) begin
          state_d = S_DATA;
        end
      end
      S_DATA: begin
        cnt_en = 1'b1;
        if (terminal || timeout) begin
          state_d       = S_ACK;
          done_valid_d  = 1'b1;
          done_status_d = terminal ? ST_OK : ST_ERR;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      src_q         <= '0;
      dest_q        <= '0;
      len_q         <= '0;
      gap_q         <= '0;
      done_valid_q  <= 1'b0;
      done_status_q <= ST_OK;
    end else begin
      state_q       <= state_d;
      src_q         <= src_d;
      dest_q        <= dest_d;
      len_q         <= len_d;
      gap_q         <= gap_d;
      done_valid_q  <= done_valid_d;
      done_status_q <= done_status_d;
    end
  end

  bus_beat_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_beat_counter (
    .clk       (clk),
    .rst       (rst),
    .clear_i   (cnt_clear),
    .enable_i  (cnt_en),
    .beat_i    (beat),
    .len_i     (len_q),
    .count_o   (beat_count),
    .terminal_o(terminal),
    .timeout_o (timeout)
  );

  assign req_ready   = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign ack         = (state_q == S_ACK);
  assign done_valid  = done_valid_q;
  assign done_status = done_status_q;

  assign bus_valid = (state_q == S_HDR) ? 1'b1 : 1'bz;
  assign bus_data  = (state_q == S_HDR) ? make_header(dest_q, src_q, CTRL_ID) : 8'bz;

endmodule

// File: tb/tb_bus_txn_sequencer.sv
// Directed bench for bus_txn_sequencer: table of requests plus hand-written
// back-to-back, reset and stall sequences. Stall outcome depends on BUS_TIMEOUT_EN.
module tb_bus_txn_sequencer;

  localparam int GAP = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic [1:0] req_src = '0;
  logic [1:0] req_dest = '0;
  logic [7:0] req_len = '0;
  wire  [7:0] bus_data;
  wire        bus_valid;
  logic       ack, busy, done_valid, done_status;
  logic [8:0] beat_count;

  logic       node_drv = 1'b0;
  logic [7:0] node_data = '0;

  int n_cmp = 0;
  int n_bad = 0;

  assign bus_data  = node_drv ? node_data : 8'bz;
  assign bus_valid = node_drv ? 1'b1 : 1'bz;

  always #5 clk = ~clk;

  bus_txn_sequencer #(
    .GAP_CYCLES    (GAP),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_src    (req_src),
    .req_dest   (req_dest),
    .req_len    (req_len),
    .bus_data   (bus_data),
    .bus_valid  (bus_valid),
    .ack        (ack),
    .busy       (busy),
    .done_valid (done_valid),
    .done_status(done_status),
    .beat_count (beat_count)
  );

  typedef struct {
    logic [1:0] src;
    logic [1:0] dest;
    logic [7:0] len;
    bit         ok;
    logic [7:0] hdr;
  } vec_t;

  vec_t vecs [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic bus_driven();
    return (bus_valid === 1'b1);
  endfunction

  // Present a request at a negedge; it is sampled at the following posedge.
  task automatic issue(input logic [1:0] s, input logic [1:0] d, input logic [7:0] l);
    @(negedge clk);
    chk("req_ready_before", req_ready, 1);
    req_src = s; req_dest = d; req_len = l; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic expect_hdr(input logic [7:0] hdr);
    @(negedge clk);
    chk("hdr_valid", bus_driven(), 1);
    chk("hdr_data", bus_data, hdr);
    chk("hdr_busy", busy, 1);
    chk("hdr_req_ready", req_ready, 0);
    $display("txn header %02h observed", bus_data);
  endtask

  // Checks the bus stays released through the gap, then drives n beats.
  task automatic gap_and_beats(input int n);
    @(posedge clk); #1;
    for (int g = 0; g < GAP; g++) begin
      @(negedge clk);
      chk("gap_released", bus_driven(), 0);
      chk("gap_req_ready", req_ready, 0);
      @(posedge clk); #1;
    end
    for (int i = 0; i < n; i++) begin
      node_drv = 1'b1;
      node_data = 8'(i);
      @(negedge clk);
      chk("no_early_ack", ack, 0);
      @(posedge clk); #1;
    end
    node_drv = 1'b0;
  endtask

  task automatic expect_ack(input logic status, input int beats);
    @(negedge clk);
    chk("ack_high", ack, 1);
    chk("ack_done_valid", done_valid, 1);
    chk("ack_done_status", done_status, status);
    chk("ack_beat_count", beat_count, beats);
    chk("ack_released", bus_driven(), 0);
    $display("txn ack status=%0d beats=%0d", done_status, beat_count);
    @(negedge clk);
    chk("post_ack_low", ack, 0);
    chk("post_done_low", done_valid, 0);
    chk("post_req_ready", req_ready, 1);
  endtask

  initial begin
    int ack_seen;
    vecs[0] = '{src: 2'd0, dest: 2'd1, len: 8'd3,   ok: 1'b1, hdr: 8'h13};
    vecs[1] = '{src: 2'd2, dest: 2'd0, len: 8'd0,   ok: 1'b1, hdr: 8'h0B};
    vecs[2] = '{src: 2'd1, dest: 2'd2, len: 8'd255, ok: 1'b1, hdr: 8'h27};
    vecs[3] = '{src: 2'd2, dest: 2'd2, len: 8'd1,   ok: 1'b0, hdr: 8'h00};
    vecs[4] = '{src: 2'd3, dest: 2'd1, len: 8'd1,   ok: 1'b0, hdr: 8'h00};
    vecs[5] = '{src: 2'd1, dest: 2'd3, len: 8'd1,   ok: 1'b0, hdr: 8'h00};

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_req_ready", req_ready, 1);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done_valid", done_valid, 0);
    chk("rst_done_status", done_status, 0);
    chk("rst_beat_count", beat_count, 0);
    chk("rst_released", bus_driven(), 0);
    @(posedge clk); #1;
    rst = 1'b0;

    for (int v = 0; v < 6; v++) begin
      issue(vecs[v].src, vecs[v].dest, vecs[v].len);
      if (vecs[v].ok) begin
        expect_hdr(vecs[v].hdr);
        gap_and_beats(int'(vecs[v].len) + 1);
        expect_ack(1'b0, int'(vecs[v].len) + 1);
      end else begin
        @(negedge clk);
        chk("rej_done_valid", done_valid, 1);
        chk("rej_done_status", done_status, 1);
        chk("rej_ack", ack, 0);
        chk("rej_no_hdr", bus_driven(), 0);
        chk("rej_busy", busy, 0);
        $display("txn rejected src=%0d dest=%0d status=%0d", vecs[v].src, vecs[v].dest, done_status);
        @(negedge clk);
        chk("rej_done_low", done_valid, 0);
      end
    end

    // Back-to-back: second request held high while the first is in flight
    @(negedge clk);
    req_src = 2'd0; req_dest = 2'd1; req_len = 8'd0; req_valid = 1'b1;
    @(posedge clk); #1;
    req_src = 2'd2; req_dest = 2'd1; req_len = 8'd1;
    expect_hdr(8'h13);
    gap_and_beats(1);
    expect_ack(1'b0, 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
    expect_hdr(8'h1B);
    gap_and_beats(2);
    expect_ack(1'b0, 2);

    // Reset while the header is on the bus: drivers release immediately
    issue(2'd1, 2'd2, 8'd0);
    @(negedge clk);
    chk("pre_rst_hdr", bus_driven(), 1);
    rst = 1'b1;
    #1;
    chk("rst_hdr_released", bus_driven(), 0);
    chk("rst_hdr_busy", busy, 0);
    $display("txn reset during header");
    @(posedge clk); #1;
    rst = 1'b0;

    // Reset during DATA after 2 beats, then a normal transaction
    issue(2'd0, 2'd1, 8'd3);
    expect_hdr(8'h13);
    gap_and_beats(2);
    chk("mid_beat_count", beat_count, 2);
    rst = 1'b1;
    #1;
    chk("rst_data_ack", ack, 0);
    chk("rst_data_busy", busy, 0);
    chk("rst_data_ready", req_ready, 1);
    chk("rst_data_count", beat_count, 0);
    chk("rst_data_done", done_valid, 0);
    chk("rst_data_released", bus_driven(), 0);
    $display("txn reset during data");
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("after_rst_ack", ack, 0);
    issue(2'd1, 2'd0, 8'd1);
    expect_hdr(8'h07);
    gap_and_beats(2);
    expect_ack(1'b0, 2);

    // Source stalls after 1 of 4 beats
    issue(2'd0, 2'd1, 8'd3);
    expect_hdr(8'h13);
    gap_and_beats(1);
`ifdef BUS_TIMEOUT_EN
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("stall_no_ack", ack, 0);
    end
    expect_ack(1'b1, 1);
`else
    ack_seen = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (ack === 1'b1) ack_seen++;
    end
    chk("stall_ack_count", ack_seen, 0);
    chk("stall_busy", busy, 1);
    chk("stall_beat_count", beat_count, 1);
    $display("txn stalled %0d cycles, ack pulses=%0d", 100, ack_seen);
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
